fetch_pair_ctrl: RTL and testbench
==================================

Name: fetch_pair_ctrl

Overview:
Dual-issue fetch sequencer for the superscalar core's two-port instruction memory. It owns the PC and drives both memory read ports (address plus active-low read enable). It captures each instruction pair into a small fetch queue and hands pairs to decode over a valid/ready handshake. It also folds unconditional jumps in fetch, applies redirects from execute, and stops on fetch faults.

Parameters:
RESET_PC, 32'h00400000, PC loaded by reset.
FQ_DEPTH, 4, fetch-queue depth in pair entries (power of 2, ≥2).
BAD_WORD, 32'hFFFFFFFF, memory default word; treated as fetch fault.
J_OPCODE, 6'h02, opcode of the folded jump.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mem_rd_n_1  out  1  read enable port 1, active-low
mem_rd_n_2  out  1  read enable port 2, active-low
mem_addr_1  out  32  port 1 address = pc
mem_addr_2  out  32  port 2 address = pc+4
mem_data_1  in  32  port 1 word (combinational, same cycle)
mem_data_2  in  32  port 2 word
redirect_valid  in  1  execute redirect (taken branch, bne/beq)
redirect_pc  in  32  redirect target
pair_valid  out  1  queue head valid
dec_ready  in  1  decode accepts head
pair_pc  out  32  PC of head slot 1
pair_instr_1  out  32  head slot 1 word
pair_instr_2  out  32  head slot 2 word
pair_v2  out  1  slot 2 valid
fetch_fault  out  1  sticky fault flag

Behaviour:
- Reset (rst=1 at posedge): state IDLE; pc=RESET_PC; queue empty; pair_valid=0; fetch_fault=0; mem_rd_n_1/2=1. All outputs take these values the cycle after reset is sampled. Mid-operation reset discards everything.
- States:
  - IDLE: one cycle after reset, then FETCH.
  - FETCH: fetching.
  - HOLD: queue full.
  - FAULT: stopped.
- Read enables: mem_rd_n_1/2 = 0 only in FETCH; 1 otherwise. Addresses always reflect pc and pc+4.
- FETCH, queue not full, no redirect: enqueue {pc, mem_data_1, mem_data_2, v2} at posedge. Zero-cycle memory latency; an entry is visible at the head the cycle after enqueue.
  - Normal case: v2=1 and pc += 8.
  - Jump folding: if mem_data_1[31:26]==J_OPCODE, then v2=0 and pc = {pc[31:28], mem_data_1[25:0], 2'b00}. There is no delay slot.
  - mem_data_1==BAD_WORD: no enqueue; fetch_fault=1; go to FAULT.
  - mem_data_2==BAD_WORD (slot 1 good, not a jump): enqueue with v2=0; fetch_fault=1; go to FAULT.
- Queue full in FETCH or HOLD: no enqueue, pc frozen, state HOLD. Return to FETCH the cycle after count < FQ_DEPTH. A same-cycle dequeue does not permit enqueue when full, so one bubble is accepted.
- Dequeue: occurs when pair_valid && dec_ready. The head advances at posedge. Head outputs are registered and stable while pair_valid && !dec_ready.
- Redirect has the highest priority, in any state except IDLE:
  - Queue flushes, including any same-cycle dequeue/enqueue.
  - pc=redirect_pc; next state FETCH; fetch_fault cleared.
  - If redirect_pc[1:0]!=0: fetch_fault=1 and state FAULT instead.
- FAULT: fetch stops. The queue still drains to decode. Exit only via redirect or rst.
- pc arithmetic is modulo 2^32; pc+4 and pc+8 wrap silently.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC, BAD_WORD, NOP_WORD (32'h38000000).
  - Opcode constants: J=6'h02, BEQ=6'h04, BNE=6'h05.
  - fq_entry_t {pc, i1, i2, v2}.
  - State enum {IDLE, FETCH, HOLD, FAULT}.
- One sub-module: fetch_queue. It is a synchronous FIFO of fq_entry_t with depth FQ_DEPTH, plus push, pop, flush, full, empty and count. Flush has priority over push and pop.

Test Plan:
1. Release rst, dec_ready=1 → cycle 1 IDLE with rd_n=1; cycle 2 addr 0x00400000/0x00400004 and rd_n=0; first pair_pc=0x00400000, instrs 0x38000000/0x38000000, v2=1; next pc 0x00400008.
2. Sequential fetch reaches 0x004000A0 (word 0x0810004C) → pair v2=0, next mem_addr_1=0x00400130, no entry for 0x004000A4.
3. dec_ready=0 for 8 cycles from reset → 4 entries, state HOLD, rd_n=1, pc frozen at 0x00400020. Raise dec_ready → head pops every cycle, fetch resumes, pc continues 0x00400020.
4. redirect_valid with redirect_pc=0x00400120 while queue holds 3 entries → next cycle pair_valid=0, mem_addr_1=0x00400120; following pair add/addu (0x8232A820/0x852AB021).
5. redirect_pc=0x00400200 (unmapped, returns 0xFFFFFFFF) → fetch_fault=1, FAULT, rd_n=1, no enqueue. Then redirect to 0x00400000 → fault cleared, fetch resumes.
6. redirect_pc=0x00400002 → fetch_fault=1 immediately and no read issued. Also assert rst during HOLD with full queue → pair_valid=0 and pc=0x00400000 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch sequencer.
//   RESET_PC / BAD_WORD / NOP_WORD : architectural constants
//   OP_J / OP_BEQ / OP_BNE         : opcode field values
//   fq_entry_t                     : one fetch-queue entry (pair of words)
//   fetch_state_t                  : sequencer state
package fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] BAD_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD = 32'h3800_0000;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        v2;
  } fq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FAULT
  } fetch_state_t;

  // Pseudo-direct jump target: keep the current 256 MB region.
  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch pairs.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : discard all entries (wins over push/pop)
//   push, din     : enqueue an entry (ignored when full)
//   pop           : advance the head (ignored when empty)
//   dout          : head entry, read from registered storage
//   full, empty   : occupancy flags
//   count         : number of held entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fq_entry_t                din,
  output fq_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fq_entry_t       store [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_pair_ctrl.sv
// Dual-issue fetch sequencer.
//   clk, rst                    : clock, synchronous active-high reset
//   mem_rd_n_1/2, mem_addr_1/2  : two-port instruction memory reads (pc, pc+4)
//   mem_data_1/2                : combinational read data
//   redirect_valid/redirect_pc  : redirect from execute
//   pair_valid, dec_ready       : handshake to decode
//   pair_pc, pair_instr_1/2     : head pair
//   pair_v2                     : head slot 2 valid
//   fetch_fault                 : sticky fault flag
module fetch_pair_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [31:0] BAD_WORD = fetch_pkg::BAD_WORD,
  parameter logic [5:0]  J_OPCODE = fetch_pkg::OP_J
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd_n_1,
  output logic        mem_rd_n_2,
  output logic [31:0] mem_addr_1,
  output logic [31:0] mem_addr_2,
  input  logic [31:0] mem_data_1,
  input  logic [31:0] mem_data_2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        pair_valid,
  input  logic        dec_ready,
  output logic [31:0] pair_pc,
  output logic [31:0] pair_instr_1,
  output logic [31:0] pair_instr_2,
  output logic        pair_v2,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  fetch_state_t   state, state_n;
  logic [31:0]    pc, pc_n;
  logic           fault, fault_n;

  logic           push, pop, flush;
  fq_entry_t      entry, head;
  logic           q_full, q_empty;
  logic [CW-1:0]  q_count;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign pop          = pair_valid && dec_ready;
  assign pair_valid   = !q_empty;
  assign pair_pc      = head.pc;
  assign pair_instr_1 = head.i1;
  assign pair_instr_2 = head.i2;
  assign pair_v2      = head.v2;

  assign mem_addr_1   = pc;
  assign mem_addr_2   = pc + 32'd4;
  assign mem_rd_n_1   = (state != FETCH);
  assign mem_rd_n_2   = (state != FETCH);
  assign fetch_fault  = fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      fault <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    fault_n = fault;
    push    = 1'b0;
    flush   = 1'b0;
    entry   = '{pc: pc, i1: mem_data_1, i2: mem_data_2, v2: 1'b1};

    if (state == IDLE) begin
      state_n = FETCH;
    end else if (redirect_valid) begin
      // Flush also swallows any same-cycle pop/push in the queue.
      flush = 1'b1;
      pc_n  = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_n = 1'b1;
        state_n = FAULT;
      end else begin
        fault_n = 1'b0;
        state_n = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (q_full) begin
            // Full is judged before any same-cycle pop: one bubble.
            state_n = HOLD;
          end else if (mem_data_1 == BAD_WORD) begin
            fault_n = 1'b1;
            state_n = FAULT;
          end else if (mem_data_1[31:26] == J_OPCODE) begin
            push     = 1'b1;
            entry.v2 = 1'b0;
            pc_n     = jump_target(pc[31:28], mem_data_1[25:0]);
          end else if (mem_data_2 == BAD_WORD) begin
            push     = 1'b1;
            entry.v2 = 1'b0;
            fault_n  = 1'b1;
            state_n  = FAULT;
          end else begin
            push = 1'b1;
            pc_n = pc + 32'd8;
          end
        end
        HOLD: begin
          if (q_count < DEPTH_C) state_n = FETCH;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pair_ctrl.sv
module tb_fetch_pair_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h3800_0000;
  localparam logic [31:0] BAD    = 32'hFFFF_FFFF;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst, dec_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_rd_n_1, mem_rd_n_2;
  logic [31:0] mem_addr_1, mem_addr_2, mem_data_1, mem_data_2;
  logic        pair_valid, pair_v2, fetch_fault;
  logic [31:0] pair_pc, pair_instr_1, pair_instr_2;

  always #5 clk = ~clk;

  // Instruction memory: 128 words mapped at RST_PC, everything else reads BAD.
  logic [31:0] imem [128];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RST_PC;
    if (a >= RST_PC && a < RST_PC + 32'h200) return imem[off[8:2]];
    return BAD;
  endfunction

  assign mem_data_1 = rd_word(mem_addr_1);
  assign mem_data_2 = rd_word(mem_addr_2);

  fetch_pair_ctrl #(
    .RESET_PC (RST_PC),
    .FQ_DEPTH (DEPTH),
    .BAD_WORD (BAD),
    .J_OPCODE (6'h02)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_n_1     (mem_rd_n_1),
    .mem_rd_n_2     (mem_rd_n_2),
    .mem_addr_1     (mem_addr_1),
    .mem_addr_2     (mem_addr_2),
    .mem_data_1     (mem_data_1),
    .mem_data_2     (mem_data_2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pair_valid     (pair_valid),
    .dec_ready      (dec_ready),
    .pair_pc        (pair_pc),
    .pair_instr_1   (pair_instr_1),
    .pair_instr_2   (pair_instr_2),
    .pair_v2        (pair_v2),
    .fetch_fault    (fetch_fault)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: pc, fault flag, activity flags and a queue of pairs.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    bit          v2;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_fault, m_starting, m_waiting, m_stopped;

  task automatic model_edge(input bit r, input bit dr, input bit rv, input logic [31:0] rp);
    bit          was_full;
    logic [31:0] w1, w2;
    ent_t        e;
    if (r) begin
      m_q.delete();
      m_pc = RST_PC; m_fault = 0; m_starting = 1; m_waiting = 0; m_stopped = 0;
      return;
    end
    if (m_starting) begin
      m_starting = 0;
      return;
    end
    if (rv) begin
      m_q.delete();
      m_pc      = rp;
      m_waiting = 0;
      m_stopped = (rp[1:0] != 2'b00);
      m_fault   = m_stopped;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    if (dr && m_q.size() > 0) void'(m_q.pop_front());
    if (!m_stopped) begin
      if (m_waiting) m_waiting = was_full;
      else if (was_full) m_waiting = 1;
      else begin
        w1 = rd_word(m_pc);
        w2 = rd_word(m_pc + 32'd4);
        e.pc = m_pc; e.i1 = w1; e.i2 = w2;
        if (w1 == BAD) begin
          m_fault = 1; m_stopped = 1;
        end else if (w1[31:26] == 6'h02) begin
          e.v2 = 0; m_q.push_back(e);
          m_pc = {m_pc[31:28], w1[25:0], 2'b00};
        end else if (w2 == BAD) begin
          e.v2 = 0; m_q.push_back(e);
          m_fault = 1; m_stopped = 1;
        end else begin
          e.v2 = 1; m_q.push_back(e);
          m_pc = m_pc + 32'd8;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic exp_rd_n;
    exp_rd_n = m_starting || m_waiting || m_stopped;
    check("rd_n_1", 32'(mem_rd_n_1), 32'(exp_rd_n));
    check("rd_n_2", 32'(mem_rd_n_2), 32'(exp_rd_n));
    check("addr_1", mem_addr_1, m_pc);
    check("addr_2", mem_addr_2, m_pc + 32'd4);
    check("fault", 32'(fetch_fault), 32'(m_fault));
    check("pair_valid", 32'(pair_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("pair_pc", pair_pc, m_q[0].pc);
      check("pair_i1", pair_instr_1, m_q[0].i1);
      check("pair_i2", pair_instr_2, m_q[0].i2);
      check("pair_v2", 32'(pair_v2), 32'(m_q[0].v2));
    end
  endtask

  task automatic step(input bit r, input bit dr, input bit rv, input logic [31:0] rp);
    rst = r; dec_ready = dr; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    model_edge(r, dr, rv, rp);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0, 1, 2: return RST_PC + 32'($urandom_range(0, 63)) * 8;
      3:       return RST_PC + 32'($urandom_range(0, 127)) * 4;
      4:       return ($urandom_range(0, 1) == 0) ? 32'h0040_0200 : 32'hFFFF_FFFC;
      default: return RST_PC + 32'($urandom_range(1, 3));
    endcase
  endfunction

  initial begin
    bit found;
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 128; i++) imem[i] = NOP;
    imem[40] = 32'h0810_004C;   // 0x004000A0: j 0x00400130
    imem[72] = 32'h8232_A820;   // 0x00400120
    imem[73] = 32'h852A_B021;   // 0x00400124
    @(negedge clk);

    // Reset, IDLE, first fetch.
    step(1, 1, 0, '0);
    check("tp1_idle_rd_n", 32'(mem_rd_n_1), 32'd1);
    check("tp1_idle_valid", 32'(pair_valid), 32'd0);
    step(0, 1, 0, '0);
    check("tp1_fetch_rd_n", 32'(mem_rd_n_1), 32'd0);
    check("tp1_addr1", mem_addr_1, 32'h0040_0000);
    check("tp1_addr2", mem_addr_2, 32'h0040_0004);
    step(0, 1, 0, '0);
    check("tp1_pair_pc", pair_pc, 32'h0040_0000);
    check("tp1_i1", pair_instr_1, NOP);
    check("tp1_v2", 32'(pair_v2), 32'd1);
    check("tp1_next_pc", mem_addr_1, 32'h0040_0008);

    // Sequential fetch into the folded jump.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 1, 0, '0);
      found = pair_valid && (pair_pc == 32'h0040_00A0);
    end
    check("tp2_reach_jump", 32'(found), 32'd1);
    check("tp2_jump_v2", 32'(pair_v2), 32'd0);
    check("tp2_jump_addr", mem_addr_1, 32'h0040_0130);
    step(0, 1, 0, '0);
    check("tp2_after_jump", pair_pc, 32'h0040_0130);

    // Fill to full, hold, then drain.
    step(1, 0, 0, '0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
    check("tp3_hold_rd_n", 32'(mem_rd_n_1), 32'd1);
    check("tp3_frozen_pc", mem_addr_1, 32'h0040_0020);
    check("tp3_head", pair_pc, 32'h0040_0000);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 1, 0, '0);
      found = pair_valid && (pair_pc == 32'h0040_0020);
    end
    check("tp3_resume", 32'(found), 32'd1);

    // Redirect with three entries queued.
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
    step(0, 0, 1, 32'h0040_0120);
    check("tp4_flushed", 32'(pair_valid), 32'd0);
    check("tp4_addr", mem_addr_1, 32'h0040_0120);
    step(0, 0, 0, '0);
    check("tp4_i1", pair_instr_1, 32'h8232_A820);
    check("tp4_i2", pair_instr_2, 32'h852A_B021);

    // Redirect into unmapped space, then recover.
    step(0, 0, 1, 32'h0040_0200);
    step(0, 0, 0, '0);
    check("tp5_fault", 32'(fetch_fault), 32'd1);
    check("tp5_rd_n", 32'(mem_rd_n_1), 32'd1);
    check("tp5_no_enq", 32'(pair_valid), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0);
    step(0, 1, 1, 32'h0040_0000);
    check("tp5_cleared", 32'(fetch_fault), 32'd0);
    step(0, 1, 0, '0);
    check("tp5_refetch", 32'(pair_valid), 32'd1);

    // Misaligned redirect, then reset while holding.
    step(0, 1, 1, 32'h0040_0002);
    check("tp6_misalign", 32'(fetch_fault), 32'd1);
    check("tp6_no_read", 32'(mem_rd_n_1), 32'd1);
    step(0, 0, 1, 32'h0040_0000);
    for (int i = 0; i < 7; i++) step(0, 0, 0, '0);
    check("tp6_held", 32'(mem_rd_n_1), 32'd1);
    step(1, 0, 0, '0);
    check("tp6_rst_valid", 32'(pair_valid), 32'd0);
    check("tp6_rst_pc", mem_addr_1, 32'h0040_0000);

    // Randomised memory image and control traffic.
    for (int i = 0; i < 128; i++) begin
      int unsigned   r;
      logic [31:0]   w;
      r = $urandom_range(0, 99);
      if (r < 8) w = 32'h0800_0000 | (32'h0010_0000 + 32'($urandom_range(0, 127)));
      else if (r < 11) w = BAD;
      else begin
        w = $urandom;
        if (w[31:26] == 6'h02) w[31:26] = 6'h00;
        if (w == BAD) w = NOP;
      end
      imem[i] = w;
    end
    for (int c = 0; c < 2500; c++) begin
      bit          r, dr, rv;
      logic [31:0] rp;
      r  = ($urandom_range(0, 199) == 0);
      dr = ($urandom_range(0, 99) < 65);
      rv = ($urandom_range(0, 99) < 5);
      rp = pick_target();
      step(r, dr, rv, rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
